// File: rtl/poly_note_sine_gen.sv
// Polyphonic sine note generator: CHANNELS voices stepped through a sine table, attenuated,
// mixed into one excess-offset sample and turned into a 1-bit speaker stream by a sigma-delta stage.
module poly_note_sine_gen #(
  parameter int CHANNELS = 2,
  parameter int AMP_W    = 8,
  parameter int SLICES   = 100,
  parameter int DIV_W    = 16,
  localparam int MIX_W   = AMP_W + $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   note_we,
  input  logic [4*CHANNELS-1:0] note_in,
  input  logic [2*CHANNELS-1:0] vol,
  output logic [CHANNELS-1:0]   active,
  output logic [CHANNELS-1:0]   busy,
  output logic [MIX_W-1:0]      mix_out,
  output logic                  speaker
);
  localparam int C     = 2 ** (AMP_W - 2);
  localparam int IDX_W = $clog2(SLICES);

  function automatic logic [AMP_W-1:0] sine_entry(input int i);
    real c;
    real a;
    c = real'(C);
    a = c + (c - 1.0) * $sin(2.0 * 3.141592653589793 * real'(i) / real'(SLICES));
    return AMP_W'($rtoi(a + 0.5));
  endfunction

  function automatic logic [DIV_W-1:0] note_div(input logic [3:0] n);
    case (n)
      4'd1:    return DIV_W'(458);
      4'd2:    return DIV_W'(408);
      4'd3:    return DIV_W'(364);
      4'd4:    return DIV_W'(344);
      4'd5:    return DIV_W'(306);
      4'd6:    return DIV_W'(229);
      4'd7:    return DIV_W'(204);
      4'd8:    return DIV_W'(182);
      4'd9:    return DIV_W'(172);
      4'd10:   return DIV_W'(153);
      default: return '0;
    endcase
  endfunction

  logic [AMP_W-1:0] sine_rom [SLICES];
  for (genvar i = 0; i < SLICES; i++) begin : g_rom
    assign sine_rom[i] = sine_entry(i);
  end

  logic [3:0]       cur_q  [CHANNELS];
  logic [3:0]       cur_d  [CHANNELS];
  logic [3:0]       pend_q [CHANNELS];
  logic [3:0]       pend_d [CHANNELS];
  logic [DIV_W-1:0] cnt_q  [CHANNELS];
  logic [DIV_W-1:0] cnt_d  [CHANNELS];
  logic [IDX_W-1:0] idx_q  [CHANNELS];
  logic [IDX_W-1:0] idx_d  [CHANNELS];
  logic [CHANNELS-1:0] pend_vld_q, pend_vld_d;
  logic [CHANNELS-1:0] active_q, active_d;
  logic [CHANNELS-1:0] busy_q, busy_d;
  logic [MIX_W-1:0]    mix_q, mix_d;
  logic [MIX_W-1:0]    acc_q, acc_d;
  logic                spk_q, spk_d;

  // A silent channel takes a new note at once; a playing one defers it to the period wrap.
  always_comb begin : p_voice
    logic [DIV_W-1:0] div_c;
    for (int c = 0; c < CHANNELS; c++) begin
      cur_d[c]      = cur_q[c];
      pend_d[c]     = pend_q[c];
      pend_vld_d[c] = pend_vld_q[c];
      cnt_d[c]      = cnt_q[c];
      idx_d[c]      = idx_q[c];
      div_c         = note_div(cur_q[c]);
      if (div_c == '0) begin
        cnt_d[c] = '0;
        idx_d[c] = '0;
        if (note_we[c]) begin
          cur_d[c] = note_in[4*c +: 4];
        end
      end else begin
        if (cnt_q[c] == div_c - DIV_W'(1)) begin
          cnt_d[c] = '0;
          if (idx_q[c] == IDX_W'(SLICES - 1)) begin
            idx_d[c] = '0;
            if (pend_vld_q[c]) begin
              cur_d[c]      = pend_q[c];
              pend_vld_d[c] = 1'b0;
            end
          end else begin
            idx_d[c] = idx_q[c] + IDX_W'(1);
          end
        end else begin
          cnt_d[c] = cnt_q[c] + DIV_W'(1);
        end
        if (note_we[c]) begin
          pend_d[c]     = note_in[4*c +: 4];
          pend_vld_d[c] = 1'b1;
        end
      end
      active_d[c] = (note_div(cur_d[c]) != '0);
      busy_d[c]   = pend_vld_d[c];
    end
  end

  // Sums are taken modulo 2^MIX_W; the true total always fits, so wrap-around is harmless.
  always_comb begin : p_mix
    logic signed [AMP_W-1:0] s;
    s     = '0;
    mix_d = MIX_W'(CHANNELS * C);
    for (int c = 0; c < CHANNELS; c++) begin
      s     = $signed(sine_rom[idx_q[c]] - AMP_W'(C));
      s     = s >>> vol[2*c +: 2];
      mix_d = mix_d + MIX_W'(s);
    end
  end

  always_comb begin : p_sd
    logic [MIX_W:0] sum;
    sum   = {1'b0, acc_q} + {1'b0, mix_q};
    acc_d = sum[MIX_W-1:0];
    spk_d = sum[MIX_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cur_q[c]  <= '0;
        pend_q[c] <= '0;
        cnt_q[c]  <= '0;
        idx_q[c]  <= '0;
      end
      pend_vld_q <= '0;
      active_q   <= '0;
      busy_q     <= '0;
      mix_q      <= MIX_W'(CHANNELS * C);
      acc_q      <= '0;
      spk_q      <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        cur_q[c]  <= cur_d[c];
        pend_q[c] <= pend_d[c];
        cnt_q[c]  <= cnt_d[c];
        idx_q[c]  <= idx_d[c];
      end
      pend_vld_q <= pend_vld_d;
      active_q   <= active_d;
      busy_q     <= busy_d;
      mix_q      <= mix_d;
      acc_q      <= acc_d;
      spk_q      <= spk_d;
    end
  end

  assign active  = active_q;
  assign busy    = busy_q;
  assign mix_out = mix_q;
  assign speaker = spk_q;

endmodule
